frame_collision_unit: RTL and testbench



---
 rtl/frame_collision_unit_pkg.sv | 41 ++++
 rtl/frame_collision_unit_if.sv | 16 +
 rtl/frame_collision_unit_probe.sv | 32 +++
 rtl/frame_collision_unit.sv | 191 +++++++++++++++++++
 tb/tb_frame_collision_unit.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_collision_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : fcu_pkg
// Purpose  : Shared collision codes, FSM state type and result encoder for
//            the per-frame collision unit.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
package fcu_pkg;

  localparam logic [2:0] CC_NONE   = 3'd0;
  localparam logic [2:0] CC_TOP    = 3'd1;
  localparam logic [2:0] CC_BOTTOM = 3'd2;
  localparam logic [2:0] CC_LEFT   = 3'd3;
  localparam logic [2:0] CC_RIGHT  = 3'd4;
  localparam logic [2:0] CC_LOST   = 3'd7;

  // Flag vector bit order shared by the probe array and the encoder.
  localparam int FLAG_TOP    = 3;
  localparam int FLAG_BOTTOM = 2;
  localparam int FLAG_LEFT   = 1;
  localparam int FLAG_RIGHT  = 0;

  typedef enum logic [0:0] {
    ST_SCAN    = 1'b0,
    ST_RESOLVE = 1'b1
  } fcu_state_t;

  // Ball lost dominates, then top > bottom > left > right.
  function automatic logic [2:0] resolve_code(input logic lost, input logic [3:0] flags);
    logic [2:0] code;
    code = CC_NONE;
    if (lost)                   code = CC_LOST;
    else if (flags[FLAG_TOP])    code = CC_TOP;
    else if (flags[FLAG_BOTTOM]) code = CC_BOTTOM;
    else if (flags[FLAG_LEFT])   code = CC_LEFT;
    else if (flags[FLAG_RIGHT])  code = CC_RIGHT;
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_collision_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : frame_collision_unit_if
// Purpose  : Valid/ack handshake carrying the per-frame collision result
//            from the pixel-domain engine to the ball logic.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface frame_collision_unit_if;
  logic       coll_valid;
  logic [2:0] coll_code;
  logic       coll_ack;

  modport master (output coll_valid, output coll_code, input  coll_ack);
  modport slave  (input  coll_valid, input  coll_code, output coll_ack);
endinterface
`default_nettype wire

// File: rtl/frame_collision_unit_probe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : collision_probe
// Purpose  : Compares the raster position with one probe point. The probe
//            point carries one extra MSB; a set MSB means the point under-
//            or overflowed the screen and the probe is disabled.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module collision_probe #(
  parameter int COORD_W = 10
) (
  input  wire logic [COORD_W-1:0] x_pixel,
  input  wire logic [COORD_W-1:0] y_pixel,
  input  wire logic [COORD_W:0]   probe_x,
  input  wire logic [COORD_W:0]   probe_y,
  input  wire logic               active,
  input  wire logic               obstacle,
  output logic                    hit
);

  logic probe_en;

  // Probe hits only on an on-screen point under a visible obstacle pixel.
  always_comb begin
    probe_en = ~probe_x[COORD_W] & ~probe_y[COORD_W];
    hit      = probe_en & active & obstacle
             & (probe_x[COORD_W-1:0] == x_pixel)
             & (probe_y[COORD_W-1:0] == y_pixel);
  end

endmodule
`default_nettype wire

// File: rtl/frame_collision_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : frame_collision_unit
// Purpose  : Per-frame ball collision detection and brick bookkeeping.
//            Four probes accumulate sticky hit flags over a frame; the flags
//            are resolved to one code per frame and offered over valid/ack.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module frame_collision_unit
  import fcu_pkg::*;
#(
  parameter int NUM_BLOCKS = 20,
  parameter int COORD_W    = 10,
  parameter int PROBE_OFS  = 5,
  parameter int LOST_Y     = 530
) (
  input  wire logic                  pixel_clk,
  input  wire logic                  rst,
  input  wire logic [COORD_W-1:0]    x_pixel,
  input  wire logic [COORD_W-1:0]    y_pixel,
  input  wire logic                  active,
  input  wire logic                  frame_start,
  input  wire logic [COORD_W-1:0]    ball_x,
  input  wire logic [COORD_W-1:0]    ball_y,
  input  wire logic [4:0]            ball_size,
  input  wire logic                  solid,
  input  wire logic [NUM_BLOCKS-1:0] block_pix,
  input  wire logic                  level_reset,
  frame_collision_unit_if.master     coll_if,
  output logic                       overrun,
  output logic [NUM_BLOCKS-1:0]      blocks_alive,
  output logic [5:0]                 blocks_left,
  output logic                       level_clear
);

  localparam logic [COORD_W:0]      OFS_W    = (COORD_W+1)'(PROBE_OFS);
  localparam logic [COORD_W-1:0]    LOST_Y_W = COORD_W'(LOST_Y);
  localparam logic [NUM_BLOCKS-1:0] ONE_B    = NUM_BLOCKS'(1);
  localparam logic [5:0]            NUM_B6   = 6'(NUM_BLOCKS);

  fcu_state_t            state_q, state_d;
  logic [3:0]            flags_q, flags_d;
  logic [3:0]            snap_q, snap_d;
  logic                  lost_q, lost_d;
  logic                  armed_q, armed_d;
  logic                  coll_valid_q, coll_valid_d;
  logic [2:0]            coll_code_q, coll_code_d;
  logic                  overrun_q, overrun_d;
  logic [NUM_BLOCKS-1:0] blocks_alive_q, blocks_alive_d;
  logic [5:0]            blocks_left_q, blocks_left_d;
  logic                  level_clear_q, level_clear_d;

  logic [COORD_W:0]      bx, by, size_w, half;
  logic [COORD_W:0]      probe_x [4];
  logic [COORD_W:0]      probe_y [4];
  logic [3:0]            probe_hit;
  logic [NUM_BLOCKS-1:0] alive_pix, kill_mask;
  logic                  brick_under, obstacle;

  // Probe coordinates with one guard bit so wrap-around shows up in the MSB.
  always_comb begin
    bx     = {1'b0, ball_x};
    by     = {1'b0, ball_y};
    size_w = (COORD_W+1)'(ball_size);
    half   = size_w >> 1;
    probe_x[FLAG_TOP]    = bx + half;
    probe_y[FLAG_TOP]    = by - OFS_W;
    probe_x[FLAG_BOTTOM] = bx + half;
    probe_y[FLAG_BOTTOM] = by + size_w + OFS_W;
    probe_x[FLAG_LEFT]   = bx - OFS_W;
    probe_y[FLAG_LEFT]   = by + half;
    probe_x[FLAG_RIGHT]  = bx + size_w + OFS_W;
    probe_y[FLAG_RIGHT]  = by + half;
  end

  // Only live bricks count as obstacles; the kill targets the lowest one.
  always_comb begin
    alive_pix   = block_pix & blocks_alive_q;
    brick_under = |alive_pix;
    obstacle    = solid | brick_under;
    kill_mask   = alive_pix & (~alive_pix + ONE_B);
  end

  for (genvar i = 0; i < 4; i++) begin : g_probe
    collision_probe #(
      .COORD_W (COORD_W)
    ) u_probe (
      .x_pixel  (x_pixel),
      .y_pixel  (y_pixel),
      .probe_x  (probe_x[i]),
      .probe_y  (probe_y[i]),
      .active   (active),
      .obstacle (obstacle),
      .hit      (probe_hit[i])
    );
  end

  // Brick state: level_reset re-arms and overrides any kill in the same cycle.
  always_comb begin
    blocks_alive_d = blocks_alive_q;
    blocks_left_d  = blocks_left_q;
    if (level_reset) begin
      blocks_alive_d = '1;
      blocks_left_d  = NUM_B6;
    end else if ((|probe_hit) && brick_under) begin
      blocks_alive_d = blocks_alive_q & ~kill_mask;
      blocks_left_d  = blocks_left_q - 6'd1;
    end
    level_clear_d = (blocks_left_q == 6'd1) && (blocks_left_d == 6'd0);
  end

  // Frame FSM: snapshot flags at frame_start, resolve and publish next cycle.
  // The first frame_start after reset only arms, so a frame cut short by
  // reset never produces a result.
  always_comb begin
    state_d      = state_q;
    flags_d      = flags_q | probe_hit;
    snap_d       = snap_q;
    lost_d       = lost_q;
    armed_d      = armed_q;
    coll_valid_d = coll_valid_q;
    coll_code_d  = coll_code_q;
    overrun_d    = overrun_q;

    if (coll_valid_q && coll_if.coll_ack) begin
      coll_valid_d = 1'b0;
    end

    case (state_q)
      ST_SCAN: begin
        if (frame_start) begin
          flags_d = probe_hit;
          armed_d = 1'b1;
          if (armed_q) begin
            snap_d  = flags_q;
            lost_d  = ball_y > LOST_Y_W;
            state_d = ST_RESOLVE;
          end
        end
      end
      ST_RESOLVE: begin
        if (!coll_valid_q || coll_if.coll_ack) begin
          coll_valid_d = 1'b1;
          coll_code_d  = resolve_code(lost_q, snap_q);
        end else begin
          overrun_d = 1'b1;
        end
        state_d = ST_SCAN;
      end
      default: state_d = ST_SCAN;
    endcase
  end

  // State and result registers.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_SCAN;
      flags_q        <= '0;
      snap_q         <= '0;
      lost_q         <= 1'b0;
      armed_q        <= 1'b0;
      coll_valid_q   <= 1'b0;
      coll_code_q    <= CC_NONE;
      overrun_q      <= 1'b0;
      blocks_alive_q <= '1;
      blocks_left_q  <= NUM_B6;
      level_clear_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      flags_q        <= flags_d;
      snap_q         <= snap_d;
      lost_q         <= lost_d;
      armed_q        <= armed_d;
      coll_valid_q   <= coll_valid_d;
      coll_code_q    <= coll_code_d;
      overrun_q      <= overrun_d;
      blocks_alive_q <= blocks_alive_d;
      blocks_left_q  <= blocks_left_d;
      level_clear_q  <= level_clear_d;
    end
  end

  assign coll_if.coll_valid = coll_valid_q;
  assign coll_if.coll_code  = coll_code_q;
  assign overrun            = overrun_q;
  assign blocks_alive       = blocks_alive_q;
  assign blocks_left        = blocks_left_q;
  assign level_clear        = level_clear_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_collision_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_frame_collision_unit
// Purpose  : Directed self-checking bench for frame_collision_unit.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_frame_collision_unit;

  logic        pixel_clk = 1'b0;
  logic        rst;
  logic [9:0]  x_pixel, y_pixel;
  logic        active;
  logic        frame_start;
  logic [9:0]  ball_x, ball_y;
  logic [4:0]  ball_size;
  logic        solid;
  logic [19:0] block_pix;
  logic        level_reset;
  logic        overrun;
  logic [19:0] blocks_alive;
  logic [5:0]  blocks_left;
  logic        level_clear;

  frame_collision_unit_if coll_if ();

  frame_collision_unit #(
    .NUM_BLOCKS (20),
    .COORD_W    (10),
    .PROBE_OFS  (5),
    .LOST_Y     (530)
  ) dut (
    .pixel_clk    (pixel_clk),
    .rst          (rst),
    .x_pixel      (x_pixel),
    .y_pixel      (y_pixel),
    .active       (active),
    .frame_start  (frame_start),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .ball_size    (ball_size),
    .solid        (solid),
    .block_pix    (block_pix),
    .level_reset  (level_reset),
    .coll_if      (coll_if),
    .overrun      (overrun),
    .blocks_alive (blocks_alive),
    .blocks_left  (blocks_left),
    .level_clear  (level_clear)
  );

  always #5 pixel_clk = ~pixel_clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic idle();
    x_pixel   = 10'd500;
    y_pixel   = 10'd500;
    solid     = 1'b0;
    block_pix = '0;
  endtask

  task automatic hit_at(input logic [9:0] x, input logic [9:0] y,
                        input logic s, input logic [19:0] bp);
    x_pixel   = x;
    y_pixel   = y;
    solid     = s;
    block_pix = bp;
    step();
    idle();
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic do_ack(input string tag);
    coll_if.coll_ack = 1'b1;
    step();
    coll_if.coll_ack = 1'b0;
    chk(tag, 32'(coll_if.coll_valid), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"},   32'(coll_if.coll_valid), 32'd0);
    chk({tag, "_code"},    32'(coll_if.coll_code),  32'd0);
    chk({tag, "_overrun"}, 32'(overrun),            32'd0);
    chk({tag, "_alive"},   32'(blocks_alive),       32'hFFFFF);
    chk({tag, "_left"},    32'(blocks_left),        32'd20);
    chk({tag, "_lclear"},  32'(level_clear),        32'd0);
  endtask

  // Ball (100,100) size 20: probes top (110,95) bottom (110,125)
  // left (95,110) right (125,110).
  initial begin
    rst              = 1'b1;
    active           = 1'b1;
    frame_start      = 1'b0;
    ball_x           = 10'd100;
    ball_y           = 10'd100;
    ball_size        = 5'd20;
    level_reset      = 1'b0;
    coll_if.coll_ack = 1'b0;
    idle();
    step();
    step();
    chk_reset_vals("reset");
    rst = 1'b0;
    step();

    // First frame_start after reset only arms.
    frame_pulse();
    step();
    chk("arm_no_result", 32'(coll_if.coll_valid), 32'd0);

    // Single top hit, latency and handshake.
    hit_at(10'd110, 10'd95, 1'b1, '0);
    step();
    frame_pulse();
    chk("latency_resolve", 32'(coll_if.coll_valid), 32'd0);
    step();
    chk("top_valid", 32'(coll_if.coll_valid), 32'd1);
    chk("top_code",  32'(coll_if.coll_code),  32'd1);
    do_ack("top_ack_drop");

    // Top and right in one frame: top has priority.
    hit_at(10'd110, 10'd95, 1'b1, '0);
    hit_at(10'd125, 10'd110, 1'b1, '0);
    frame_pulse();
    step();
    chk("prio_code", 32'(coll_if.coll_code), 32'd1);
    // Empty frame; ack lands on the RESOLVE cycle.
    frame_pulse();
    coll_if.coll_ack = 1'b1;
    step();
    coll_if.coll_ack = 1'b0;
    chk("ackload_valid",   32'(coll_if.coll_valid), 32'd1);
    chk("flags_cleared",   32'(coll_if.coll_code),  32'd0);
    chk("ackload_overrun", 32'(overrun),            32'd0);
    do_ack("empty_ack_drop");

    // Bricks 3 and 5 under bottom probe: only brick 3 dies.
    hit_at(10'd110, 10'd125, 1'b0, 20'h00028);
    chk("kill_low_alive", 32'(blocks_alive), 32'hFFFF7);
    chk("kill_low_left",  32'(blocks_left),  32'd19);
    frame_pulse();
    step();
    chk("bottom_code", 32'(coll_if.coll_code), 32'd2);
    do_ack("bottom_ack_drop");

    // level_reset beats a simultaneous kill.
    x_pixel     = 10'd110;
    y_pixel     = 10'd125;
    block_pix   = 20'h00001;
    level_reset = 1'b1;
    step();
    level_reset = 1'b0;
    idle();
    chk("lreset_win_alive", 32'(blocks_alive), 32'hFFFFF);
    chk("lreset_win_left",  32'(blocks_left),  32'd20);

    // Kill all 20 bricks, one per cycle.
    x_pixel   = 10'd110;
    y_pixel   = 10'd125;
    block_pix = 20'hFFFFF;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("killall_left_%0d", i),   32'(blocks_left), 32'(19 - i));
      chk($sformatf("killall_lclear_%0d", i), 32'(level_clear), (i == 19) ? 32'd1 : 32'd0);
    end
    idle();
    step();
    chk("lclear_single", 32'(level_clear),  32'd0);
    chk("all_dead",      32'(blocks_alive), 32'd0);
    frame_pulse();
    step();
    chk("killall_code", 32'(coll_if.coll_code), 32'd2);
    do_ack("killall_ack_drop");

    // Dead bricks never hit.
    hit_at(10'd110, 10'd95, 1'b0, 20'hFFFFF);
    frame_pulse();
    step();
    chk("dead_no_hit", 32'(coll_if.coll_code), 32'd0);
    do_ack("dead_ack_drop");
    level_reset = 1'b1;
    step();
    level_reset = 1'b0;
    chk("lreset_alive", 32'(blocks_alive), 32'hFFFFF);
    chk("lreset_left",  32'(blocks_left),  32'd20);

    // Overrun: two frames without ack.
    hit_at(10'd110, 10'd95, 1'b1, '0);
    frame_pulse();
    step();
    chk("ovr_first_code", 32'(coll_if.coll_code), 32'd1);
    chk("ovr_not_yet",    32'(overrun),            32'd0);
    hit_at(10'd95, 10'd110, 1'b1, '0);
    frame_pulse();
    step();
    chk("ovr_set",    32'(overrun),            32'd1);
    chk("ovr_keep",   32'(coll_if.coll_code),  32'd1);
    chk("ovr_valid",  32'(coll_if.coll_valid), 32'd1);
    do_ack("ovr_ack_drop");

    // Ball lost.
    ball_y = 10'd540;
    frame_pulse();
    step();
    chk("lost_code", 32'(coll_if.coll_code), 32'd7);
    chk("ovr_sticky", 32'(overrun),          32'd1);
    do_ack("lost_ack_drop");
    ball_y = 10'd100;

    // A hit on the frame_start cycle belongs to the new frame.
    x_pixel = 10'd110;
    y_pixel = 10'd95;
    solid   = 1'b1;
    frame_pulse();
    idle();
    step();
    chk("fs_hit_old_frame", 32'(coll_if.coll_code), 32'd0);
    do_ack("fs_ack1_drop");
    frame_pulse();
    step();
    chk("fs_hit_new_frame", 32'(coll_if.coll_code), 32'd1);
    do_ack("fs_ack2_drop");

    // ball_y=3: top probe underflows, no wrapped hit at y=1022.
    ball_y = 10'd3;
    hit_at(10'd110, 10'd1022, 1'b1, '0);
    frame_pulse();
    step();
    chk("top_underflow", 32'(coll_if.coll_code), 32'd0);
    do_ack("uf_ack_drop");
    ball_y = 10'd100;

    // Mid-frame reset with a pending result and a dead brick.
    hit_at(10'd110, 10'd95, 1'b1, '0);
    frame_pulse();
    step();
    hit_at(10'd110, 10'd125, 1'b0, 20'h00001);
    chk("pre_rst_alive", 32'(blocks_alive), 32'hFFFFE);
    rst = 1'b1;
    #2;
    chk_reset_vals("midrst");
    step();
    rst = 1'b0;
    step();
    hit_at(10'd110, 10'd125, 1'b1, '0);
    frame_pulse();
    step();
    chk("post_rst_arm", 32'(coll_if.coll_valid), 32'd0);
    hit_at(10'd110, 10'd95, 1'b1, '0);
    frame_pulse();
    step();
    chk("post_rst_valid", 32'(coll_if.coll_valid), 32'd1);
    chk("post_rst_code",  32'(coll_if.coll_code),  32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
